spram_fifo_ctrl: RTL and testbench
==================================

# spram_fifo_ctrl

- FIFO controller that sits directly upstream of the single-port asynchronous-read RAM.
- Owns the RAM's write-enable, output-enable, address and write-data lines, and consumes its read data.
- Presents a push/pop FIFO interface with a registered, first-word-fall-through output.
- After every reset, runs a clear sequence that zero-fills the RAM before accepting data.

## Interface

Parameters:
- DATA_WIDTH, 8, word width; must match the attached RAM.
- ADDR_WIDTH, 3, RAM address width; RAM depth DEPTH = 2**ADDR_WIDTH.

Ports:
- i_CLK  in  1  single clock; all state changes on its rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_push  in  1  write request; accepted when o_full=0.
- i_data  in  DATA_WIDTH  push data, sampled with i_push.
- i_pop  in  1  consume o_data; ignored when o_valid=0.
- o_data  out  DATA_WIDTH  head-of-FIFO word (registered).
- o_valid  out  1  o_data holds a word.
- o_full  out  1  RAM holds DEPTH words, or clear in progress.
- o_busy  out  1  clear sequence running.
- o_level  out  ADDR_WIDTH+1  words held in RAM, excluding the output register.
- ram_we  out  1  to RAM write enable.
- ram_oe  out  1  to RAM output enable.
- ram_waddr  out  ADDR_WIDTH  to RAM write address.
- ram_wdata  out  DATA_WIDTH  to RAM write data.
- ram_raddr  out  ADDR_WIDTH  to RAM read address.
- ram_rdata  in  DATA_WIDTH  from RAM read data; valid only while ram_oe=1 and ram_we=0.

## Operation

- States: CLEAR, RUN.
- i_reset=1 forces state CLEAR and clears all registers:
  - clear counter, wr_ptr, rd_ptr and count to 0;
  - o_valid=0, o_data=0.
  - While i_reset=1, ram_we=0 and ram_oe=0.
- CLEAR:
  - ram_we=1, ram_oe=0, ram_waddr=clear counter, ram_wdata=0.
  - Counter increments each cycle.
  - Exits to RUN after the cycle that writes address DEPTH-1, i.e. DEPTH cycles total.
  - o_busy=1 and o_full=1 throughout; i_push and i_pop are ignored.
- RUN: each cycle is exactly one of write, read or idle. The RAM is never written and read in the same cycle.
  - Write cycle, when i_push=1 and count<DEPTH:
    - ram_we=1, ram_oe=0, ram_waddr=wr_ptr, ram_wdata=i_data.
    - wr_ptr+1 (mod DEPTH).
  - Read cycle, when not a write cycle, count>0, and (o_valid=0 or i_pop=1):
    - ram_we=0, ram_oe=1, ram_raddr=rd_ptr.
    - o_data<=ram_rdata, o_valid<=1, rd_ptr+1 (mod DEPTH).
  - Otherwise: ram_we=0, ram_oe=0.
  - i_pop=1 with o_valid=1 and no read cycle: o_valid<=0.
- count update: +1 on a write cycle, -1 on a read cycle, never both in one cycle.
- Outputs:
  - o_level=count.
  - o_full = (state==CLEAR) or (count==DEPTH).
  - ram_raddr=rd_ptr at all times outside CLEAR.
- Push has priority over refill. Sustained pushes stall the output refill until a push-free cycle or until o_full. This is intended behaviour.
- Pointer wrap: wr_ptr and rd_ptr wrap DEPTH-1 -> 0 naturally.
- Push while full: ignored, with no state change.
- Pop while empty (o_valid=0): ignored.

## Timing

- All RAM control outputs are combinational from registered state and i_push/i_pop/count. The RAM write completes within the cycle.
- Push-to-visible latency: push accepted in cycle n, read cycle no earlier than n+1, o_valid=1 from cycle n+2.
- Pop with refill available: i_pop in cycle n, with no push in cycle n. New o_data is shown in cycle n+1 with o_valid held at 1, giving one word per cycle throughput.
- Reset to first accepted push: DEPTH+1 cycles after i_reset deasserts (DEPTH clear cycles, then RUN).
- Reset asserted mid-clear or mid-RUN: next edge restarts CLEAR from address 0. FIFO contents are lost.

## Test plan

- Clear sequence, ADDR_WIDTH=3:
  - Release reset -> 8 cycles with ram_we=1, ram_waddr 0..7, ram_wdata=0, o_busy=1, o_full=1.
  - Then o_busy=0, o_full=0, o_level=0.
- Basic ordering:
  - Push 0x11, 0x22, 0x33 in consecutive cycles, then idle.
  - o_valid rises with o_data=0x11.
  - Three pops -> 0x22, 0x33 in successive cycles, then o_valid=0 and o_level=0.
- Full/stall:
  - Push 0x01..0x09 back-to-back -> first 8 accepted, o_full=1 on the 9th cycle, ninth push ignored, no read cycle occurs.
  - One idle cycle -> read cycle, o_data=0x01, o_level=7, o_full=0.
- Wrap-around:
  - 20 pushes interleaved with pops, pattern push/idle/pop.
  - Output sequence is exactly the pushed values in order.
  - Pointers pass 7->0 at least twice with no loss or duplication.
- Simultaneous push and pop:
  - With o_valid=1 and o_level=2, assert i_push and i_pop together -> write cycle taken, o_valid=0, o_level=3.
  - Next idle cycle -> refill with the correct next word.
- Reset mid-operation:
  - With o_level=5, assert i_reset for 1 cycle -> o_valid=0, o_level=0, 8 clear cycles restart from address 0.
  - Subsequent push/pop order is correct.

Source files
------------

// File: rtl/spram_fifo_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | spram_fifo_ctrl: FIFO controller for a single-port async-read RAM with a    |
// | registered first-word-fall-through output and a zero-fill clear after reset.|
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module spram_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  i_CLK,
  input  logic                  i_reset,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_full,
  output logic                  o_busy,
  output logic [ADDR_WIDTH:0]   o_level,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam int                    c_DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   c_DEPTH_CNT = (ADDR_WIDTH+1)'(c_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = '1;

  localparam logic [0:0] c_ST_CLEAR = 1'b0;
  localparam logic [0:0] c_ST_RUN   = 1'b1;

  logic [0:0]            r_state;
  logic [0:0]            w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_clr_cnt;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  w_write;
  logic                  w_read;

  always_ff @(posedge i_CLK) begin
    if (i_reset) r_state <= c_ST_CLEAR;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_CLEAR: if (r_clr_cnt == c_LAST_ADDR) w_state_nxt = c_ST_RUN;
      default:    w_state_nxt = r_state;
    endcase
  end

  // Write wins over refill so the RAM never sees a write and a read in one cycle.
  always_comb begin
    w_write   = !i_reset && (r_state == c_ST_RUN) && i_push && (r_count != c_DEPTH_CNT);
    w_read    = !i_reset && (r_state == c_ST_RUN) && !w_write && (r_count != '0)
                && (!r_valid || i_pop);
    ram_we    = !i_reset && ((r_state == c_ST_CLEAR) || w_write);
    ram_oe    = w_read;
    ram_waddr = (r_state == c_ST_CLEAR) ? r_clr_cnt : r_wr_ptr;
    ram_wdata = (r_state == c_ST_CLEAR) ? '0 : i_data;
    ram_raddr = r_rd_ptr;
  end

  always_ff @(posedge i_CLK) begin
    if (i_reset) begin
      r_clr_cnt <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
    end else begin
      if (r_state == c_ST_CLEAR) r_clr_cnt <= r_clr_cnt + 1'b1;
      if (w_write) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_count  <= r_count + 1'b1;
      end
      if (w_read) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_count  <= r_count - 1'b1;
        r_data   <= ram_rdata;
        r_valid  <= 1'b1;
      end else if (i_pop && r_valid && (r_state == c_ST_RUN)) begin
        r_valid  <= 1'b0;
      end
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_busy  = (r_state == c_ST_CLEAR);
  assign o_full  = (r_state == c_ST_CLEAR) || (r_count == c_DEPTH_CNT);
  assign o_level = r_count;

endmodule
`default_nettype wire

// File: tb/tb_spram_fifo_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_spram_fifo_ctrl: scoreboard bench with a queue-based reference model.    |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_spram_fifo_ctrl;

  localparam int c_DW    = 8;
  localparam int c_AW    = 3;
  localparam int c_DEPTH = 1 << c_AW;

  logic              clk = 1'b0;
  logic              i_reset = 1'b1;
  logic              i_push = 1'b0;
  logic [c_DW-1:0]   i_data = '0;
  logic              i_pop = 1'b0;
  logic [c_DW-1:0]   o_data;
  logic              o_valid, o_full, o_busy;
  logic [c_AW:0]     o_level;
  logic              ram_we, ram_oe;
  logic [c_AW-1:0]   ram_waddr, ram_raddr;
  logic [c_DW-1:0]   ram_wdata, ram_rdata;
  logic [c_DW-1:0]   mem [c_DEPTH];

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // reference model: RAM contents as a queue, output register, clear cycles left
  logic [c_DW-1:0] m_ram[$];
  logic [c_DW-1:0] exp_q[$];
  bit              m_valid = 1'b0;
  logic [c_DW-1:0] m_data = '0;
  int              m_clr = c_DEPTH;
  bit              m_wr, m_rd;

  always #5 clk = ~clk;

  spram_fifo_ctrl #(.DATA_WIDTH(c_DW), .ADDR_WIDTH(c_AW)) dut (
    .i_CLK(clk), .i_reset(i_reset), .i_push(i_push), .i_data(i_data), .i_pop(i_pop),
    .o_data(o_data), .o_valid(o_valid), .o_full(o_full), .o_busy(o_busy), .o_level(o_level),
    .ram_we(ram_we), .ram_oe(ram_oe), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_raddr(ram_raddr), .ram_rdata(ram_rdata)
  );

  always @(posedge clk) if (ram_we) mem[ram_waddr] <= ram_wdata;
  assign ram_rdata = (ram_oe && !ram_we) ? mem[ram_raddr] : 8'hA5;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: each word handed over (o_valid with i_pop) must be the oldest pushed word
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (chk_en && !i_reset && o_valid && i_pop) begin
        if (exp_q.size() == 0) begin
          chk("pop_unexpected", 1, 0);
        end else begin
          chk("pop_data", int'(o_data), int'(exp_q.pop_front()));
        end
      end
    end
  end

  function automatic void model_step(input bit r, input bit p, input logic [c_DW-1:0] d, input bit q);
    if (r) begin
      m_ram.delete(); exp_q.delete();
      m_valid = 1'b0; m_data = '0; m_clr = c_DEPTH;
    end else if (m_clr > 0) begin
      m_clr--;
    end else begin
      if (m_wr) begin
        m_ram.push_back(d);
        exp_q.push_back(d);
      end
      if (m_rd) begin
        m_data  = m_ram.pop_front();
        m_valid = 1'b1;
      end else if (q && m_valid) begin
        m_valid = 1'b0;
      end
    end
  endfunction

  task automatic cyc(input bit r, input bit p, input logic [c_DW-1:0] d, input bit q);
    @(negedge clk);
    i_reset = r; i_push = p; i_data = d; i_pop = q;
    m_wr = !r && (m_clr == 0) && p && (m_ram.size() < c_DEPTH);
    m_rd = !r && (m_clr == 0) && !m_wr && (m_ram.size() > 0) && (!m_valid || q);
    #1;
    if (chk_en) begin
      chk("o_busy",  int'(o_busy),  int'(m_clr > 0));
      chk("o_full",  int'(o_full),  int'((m_clr > 0) || (m_ram.size() == c_DEPTH)));
      chk("o_level", int'(o_level), m_ram.size());
      chk("o_valid", int'(o_valid), int'(m_valid));
      chk("o_data",  int'(o_data),  int'(m_data));
      chk("ram_we",  int'(ram_we),  int'(!r && ((m_clr > 0) || m_wr)));
      chk("ram_oe",  int'(ram_oe),  int'(m_rd));
      if (!r && m_clr > 0) begin
        chk("clr_waddr", int'(ram_waddr), c_DEPTH - m_clr);
        chk("clr_wdata", int'(ram_wdata), 0);
      end
    end
    @(posedge clk);
    model_step(r, p, d, q);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < c_DEPTH; i++) cyc(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * c_DEPTH + 4 && (m_valid || m_ram.size() > 0); i++)
      cyc(1'b0, 1'b0, '0, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < c_DEPTH; i++) mem[i] = 8'hC3;
    cyc(1'b1, 1'b0, '0, 1'b0);
    chk_en = 1'b1;
    // clear sequence and idle RUN state
    for (int i = 0; i < c_DEPTH; i++) cyc(1'b0, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0);

    // basic ordering
    cyc(1'b0, 1'b1, 8'h11, 1'b0);
    cyc(1'b0, 1'b1, 8'h22, 1'b0);
    cyc(1'b0, 1'b1, 8'h33, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, '0, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b0);

    // full and push-priority stall
    for (int i = 1; i <= 9; i++) cyc(1'b0, 1'b1, 8'(i), 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0);
    drain();

    // wrap-around: push / idle / pop
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b1, 8'($urandom), 1'b0);
      cyc(1'b0, 1'b0, '0, 1'b0);
      cyc(1'b0, 1'b0, '0, 1'b1);
    end
    drain();

    // simultaneous push and pop with o_valid=1, level 2
    cyc(1'b0, 1'b1, 8'hA1, 1'b0);
    cyc(1'b0, 1'b1, 8'hA2, 1'b0);
    cyc(1'b0, 1'b1, 8'hA3, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b1, 8'hA4, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0);
    drain();

    // reset with words held
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 8'h50 + 8'(i), 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0);
    do_reset();
    cyc(1'b0, 1'b1, 8'h77, 1'b0);
    cyc(1'b0, 1'b1, 8'h88, 1'b0);
    drain();

    // randomized traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) != 0),
          8'($urandom), ($urandom_range(0, 1) == 1));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
